cond_exec_ctrl: RTL

//  Decode-to-execute conditional-execution controller for the pipelined core, successor to the combinational ALU-op squash.

---
 rtl/cond_exec_if.sv | 50 +++++
 rtl/cond_exec_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/cond_exec_if.sv
// Decode/result/execute bundle for the conditional-execution controller.
// slave = controller side, master = driver of decode and result bus.
interface cond_exec_if #(
  parameter int OP_W = 2
) ();
  logic            id_valid;
  logic            id_ready;
  logic            id_rtype;
  logic            id_c_in;
  logic            id_z_in;
  logic            id_c_wr;
  logic            id_z_wr;
  logic [OP_W-1:0] id_alu_op;
  logic            ex_hold;
  logic            flush;
  logic            res_valid;
  logic            res_c_wr;
  logic            res_z_wr;
  logic            res_carry;
  logic            res_zero;
  logic            ex_valid;
  logic [OP_W-1:0] ex_alu_op;
  logic            ex_c_wr;
  logic            ex_z_wr;
  logic            ex_squash;
  logic            flag_c;
  logic            flag_z;

  modport slave (
    input  id_valid, id_rtype, id_c_in, id_z_in,
    input  id_c_wr, id_z_wr, id_alu_op,
    input  ex_hold, flush,
    input  res_valid, res_c_wr, res_z_wr,
    input  res_carry, res_zero,
    output id_ready,
    output ex_valid, ex_alu_op, ex_c_wr, ex_z_wr,
    output ex_squash, flag_c, flag_z
  );

  modport master (
    output id_valid, id_rtype, id_c_in, id_z_in,
    output id_c_wr, id_z_wr, id_alu_op,
    output ex_hold, flush,
    output res_valid, res_c_wr, res_z_wr,
    output res_carry, res_zero,
    input  id_ready,
    input  ex_valid, ex_alu_op, ex_c_wr, ex_z_wr,
    input  ex_squash, flag_c, flag_z
  );
endinterface

// File: rtl/cond_exec_ctrl.sv
// ID->EX conditional-execution controller: C/Z flags, writer tracking, squash.
// Optional macro FLAG_FWD_EN enables flag forwarding from the result bus.
module cond_exec_ctrl #(
  parameter int              OP_W         = 2,
  parameter logic [OP_W-1:0] NOP_OP       = {OP_W{1'b1}},
  parameter int              MAX_INFLIGHT = 3
) (
  input logic      clk,
  input logic      rst,
  cond_exec_if.slave bus
);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] PMAX = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0] PONE = CW'(1);
  localparam logic [CW-1:0] PZERO = '0;

  logic [CW-1:0] pend_c;
  logic [CW-1:0] pend_z;
  logic          flag_c_q;
  logic          flag_z_q;

  logic need_c;
  logic need_z;
  logic dec_c;
  logic dec_z;
  logic c_known;
  logic z_known;
  logic eff_c;
  logic eff_z;
  logic hazard;
  logic full;
  logic ready;
  logic accept;
  logic squash;
  logic inc_c;
  logic inc_z;

  assign need_c = bus.id_rtype & bus.id_c_in & ~bus.id_z_in;
  assign need_z = bus.id_rtype & ~bus.id_c_in & bus.id_z_in;
  assign dec_c  = bus.res_valid & bus.res_c_wr;
  assign dec_z  = bus.res_valid & bus.res_z_wr;

`ifdef FLAG_FWD_EN
  // single outstanding writer retiring now: take its value off the bus
  assign c_known = (pend_c == PZERO) | ((pend_c == PONE) & dec_c);
  assign z_known = (pend_z == PZERO) | ((pend_z == PONE) & dec_z);
  assign eff_c   = (pend_c == PZERO) ? flag_c_q : bus.res_carry;
  assign eff_z   = (pend_z == PZERO) ? flag_z_q : bus.res_zero;
`else
  // flag is usable only once every writer has landed in the arch flag
  assign c_known = (pend_c == PZERO);
  assign z_known = (pend_z == PZERO);
  assign eff_c   = flag_c_q;
  assign eff_z   = flag_z_q;
`endif

  assign hazard = (need_c & ~c_known) | (need_z & ~z_known);
  assign full   = (bus.id_c_wr & (pend_c == PMAX) & ~dec_c)
                | (bus.id_z_wr & (pend_z == PMAX) & ~dec_z);
  assign ready  = ~bus.ex_hold & ~bus.flush & ~hazard & ~full;
  assign accept = bus.id_valid & ready;
  assign squash = (need_c & ~eff_c) | (need_z & ~eff_z);
  assign inc_c  = accept & ~squash & bus.id_c_wr;
  assign inc_z  = accept & ~squash & bus.id_z_wr;

  assign bus.id_ready = ready;
  assign bus.flag_c   = flag_c_q;
  assign bus.flag_z   = flag_z_q;

  // outstanding flag-writer counters, cleared by flush, floor at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_c <= '0;
      pend_z <= '0;
    end else if (bus.flush) begin
      pend_c <= '0;
      pend_z <= '0;
    end else begin
      if (inc_c && !dec_c)
        pend_c <= pend_c + PONE;
      else if (!inc_c && dec_c && pend_c != PZERO)
        pend_c <= pend_c - PONE;
      if (inc_z && !dec_z)
        pend_z <= pend_z + PONE;
      else if (!inc_z && dec_z && pend_z != PZERO)
        pend_z <= pend_z - PONE;
    end
  end

  // architectural flags follow the result bus, independent per flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      if (dec_c) flag_c_q <= bus.res_carry;
      if (dec_z) flag_z_q <= bus.res_zero;
    end
  end

  // EX stage register: issue, squash to NOP, bubble, or hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ex_valid  <= 1'b0;
      bus.ex_alu_op <= NOP_OP;
      bus.ex_c_wr   <= 1'b0;
      bus.ex_z_wr   <= 1'b0;
      bus.ex_squash <= 1'b0;
    end else if (bus.flush || (!accept && !bus.ex_hold)) begin
      bus.ex_valid  <= 1'b0;
      bus.ex_alu_op <= NOP_OP;
      bus.ex_c_wr   <= 1'b0;
      bus.ex_z_wr   <= 1'b0;
      bus.ex_squash <= 1'b0;
    end else if (accept) begin
      bus.ex_valid  <= 1'b1;
      bus.ex_alu_op <= squash ? NOP_OP : bus.id_alu_op;
      bus.ex_c_wr   <= bus.id_c_wr & ~squash;
      bus.ex_z_wr   <= bus.id_z_wr & ~squash;
      bus.ex_squash <= squash;
    end
  end
endmodule
